// File: rtl/axi_pkg.sv
// Shared AXI burst-memory types: burst encodings, response codes and engine states.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational per-beat next-address generator and burst-legality check.
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  illegal
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] incr;

    always_comb begin
        bytes     = ADDR_WIDTH'(1) << size;
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        incr      = addr + bytes;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            default:     next_addr = incr;
        endcase
        illegal = (size > MAX_SIZE) || (burst == 2'b11) ||
                  ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 slave memory with independent write and read burst engines.
module axi_burst_mem_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int MEM_DEPTH  = 1024,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int OFF   = $clog2(STRB_WIDTH);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * STRB_WIDTH);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < MEM_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> OFF);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Write engine
    w_state_e              w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr, w_next;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_err, w_illegal, w_fire, w_last, w_beat_ok, w_beat_err;

    axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_wgen (
        .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst),
        .next_addr(w_next), .illegal(w_illegal)
    );

    always_comb begin
        w_fire     = (w_state == W_DATA) && wvalid && wready;
        w_last     = (w_cnt == w_len);
        w_beat_ok  = !w_illegal && in_range(w_addr);
        w_beat_err = !w_beat_ok || (wlast != w_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
            w_err   <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        w_id    <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        w_burst <= awburst;
                        w_cnt   <= '0;
                        w_err   <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: if (w_fire) begin
                    w_addr <= w_next;
                    w_cnt  <= w_cnt + 8'd1;
                    w_err  <= w_err | w_beat_err;
                    // Burst length comes from the beat count; wlast is only cross-checked.
                    if (w_last) begin
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bid     <= w_id;
                        bresp   <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (bready) begin
                    bvalid  <= 1'b0;
                    bid     <= '0;
                    bresp   <= RESP_OKAY;
                    awready <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire && w_beat_ok && !rst) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read engine: r_addr tracks the beat currently presented on R
    r_state_e              r_state;
    logic [ADDR_WIDTH-1:0] r_addr, r_next, g_addr, r_load_addr;
    logic [7:0]            r_len, r_cnt, g_len;
    logic [2:0]            r_size, g_size;
    logic [1:0]            r_burst, g_burst;
    logic                  r_idle, r_illegal, r_load_ok;

    // In IDLE the generator checks the incoming AR request so beat 0 can load on the handshake.
    always_comb begin
        r_idle      = (r_state == R_IDLE);
        g_addr      = r_idle ? araddr  : r_addr;
        g_len       = r_idle ? arlen   : r_len;
        g_size      = r_idle ? arsize  : r_size;
        g_burst     = r_idle ? arburst : r_burst;
        r_load_addr = r_idle ? araddr  : r_next;
        r_load_ok   = !r_illegal && in_range(r_load_addr);
    end

    axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_rgen (
        .addr(g_addr), .len(g_len), .size(g_size), .burst(g_burst),
        .next_addr(r_next), .illegal(r_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        r_burst <= arburst;
                        r_cnt   <= '0;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rid     <= arid;
                        rdata   <= r_load_ok ? mem[word_idx(r_load_addr)] : '0;
                        rresp   <= r_load_ok ? RESP_OKAY : RESP_SLVERR;
                        rlast   <= (arlen == 8'd0);
                        r_state <= R_DATA;
                    end
                end
                R_DATA: if (rready) begin
                    if (rlast) begin
                        rvalid  <= 1'b0;
                        rlast   <= 1'b0;
                        rid     <= '0;
                        rdata   <= '0;
                        rresp   <= RESP_OKAY;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end else begin
                        r_addr <= r_next;
                        r_cnt  <= r_cnt + 8'd1;
                        rdata  <= r_load_ok ? mem[word_idx(r_load_addr)] : '0;
                        rresp  <= r_load_ok ? RESP_OKAY : RESP_SLVERR;
                        rlast  <= (r_cnt + 8'd1 == r_len);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
